pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline sequencer for the MIPS core: owns a valid bit per pipeline latch, generates per-latch capture enables, PC enable, load-use bubble insertion, taken-branch flush and external-stall freeze. Sits beside the stage chain (IF, IF/ID, ID, ID/EX, EX, …) and replaces fixed always-enabled latches. Also maintains a saturating load-use stall counter for performance debug.

## Interface
- STAGES, 4, number of pipeline latches controlled (index 0 = IF/ID, 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB); legal 3..8
- BRANCH_STAGE, 1, index of the latch whose output stage resolves branches; legal 0..STAGES-2
- REG_BITS, 5, register-specifier width
- CNT_W, 16, stall-counter width

- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low (asserted at 0)
- i_fetch_valid  input  1  IF stage presents a valid instruction
- i_id_rs / i_id_rt  input  REG_BITS each  source specifiers of instruction in ID (from latch 0)
- i_id_uses_rs / i_id_uses_rt  input  1 each  ID instruction actually reads rs / rt
- i_ex_mem_read  input  1  instruction in EX (from latch 1) is a load
- i_ex_rt  input  REG_BITS  load destination in EX
- i_branch_taken  input  1  branch in stage after latch BRANCH_STAGE is taken; qualified internally by that latch's valid
- i_ext_stall  input  1  memory/external busy; freezes the whole pipe
- o_pc_en  output  1  PC register may update this cycle
- o_latch_en  output  STAGES  per-latch capture enable this cycle
- o_latch_valid  output  STAGES  registered valid bit of each latch
- o_flush  output  STAGES  per-latch squash pulse (combinational, this cycle)
- o_load_use_stall  output  1  load-use bubble inserted this cycle
- o_stall_count  output  CNT_W  saturating count of load-use stall cycles

## Operation
- State: v[STAGES-1:0] (valid shift register), cnt[CNT_W-1:0]. o_latch_valid = v, o_stall_count = cnt.
- br = i_branch_taken & v[BRANCH_STAGE].
- hz = v[0] & v[1] & i_ex_mem_read & (i_ex_rt != 0) & ((i_id_uses_rs & i_id_rs == i_ex_rt) | (i_id_uses_rt & i_id_rt == i_ex_rt)).
- Per-cycle mode, priority top-down:
  - FREEZE (i_ext_stall): o_pc_en=0, o_latch_en=0, o_flush=0, v and cnt hold; br and hz ignored (sources hold them until released).
  - FLUSH (br): o_pc_en=1 (PC loads target), o_latch_en=all 1; v[k]<=0 for k<=BRANCH_STAGE, v[k]<=v[k-1] for k>BRANCH_STAGE; o_flush[k]=1 for k<=BRANCH_STAGE. hz ignored (victim is squashed).
  - BUBBLE (hz): o_pc_en=0, o_latch_en[0]=0 (IF/ID holds), o_latch_en[k>=1]=1; v[0] holds, v[1]<=0, v[k>=2]<=v[k-1]; o_load_use_stall=1; cnt<=cnt+1 unless all-ones.
  - RUN: o_pc_en=1, o_latch_en=all 1, v[0]<=i_fetch_valid, v[k]<=v[k-1].
- o_load_use_stall=1 only in BUBBLE mode; 0 in FREEZE even if hz.
- Register 0 never creates a hazard.
- Downstream stages must treat a latch with v[k]=0 as a NOP (no register/memory write).

## Timing
- Reset (reset=0, asynchronous): v=0, cnt=0 immediately; while asserted o_pc_en=0, o_latch_en=0, o_flush=0, o_load_use_stall=0. First RUN cycle on first rising clk after deassertion.
- All mode decisions combinational from current inputs and v; v/cnt update on rising clk.
- Load-use costs exactly one bubble cycle: next cycle v[1]=0 and the load is in latch 2, so hz deasserts.
- Taken branch: younger BRANCH_STAGE+1 instructions lost; first target instruction valid in latch 0 one cycle after o_pc_en captures target (fetch latency permitting).
- Fill: valid instruction reaches latch STAGES-1 after STAGES RUN cycles.
- cnt saturates at 2^CNT_W-1, never wraps.
- Reset mid-operation discards all in-flight valid bits; cnt cleared.

## Test plan
- Reset/fill: reset=0 two cycles, release, i_fetch_valid=1 constant → o_latch_valid 0000→0001→0011→0111→1111, o_pc_en=1 every cycle, o_stall_count=0.
- Load-use: full pipe, i_ex_mem_read=1, i_ex_rt=5, i_id_rs=5, uses_rs=1 for one cycle → o_pc_en=0, o_latch_en=1110, o_load_use_stall=1, next v[1]=0, o_stall_count=1; same with i_ex_rt=0 → no stall.
- Branch: full pipe, BRANCH_STAGE=1, i_branch_taken=1 → o_flush=0011, next o_latch_valid=x100 pattern (v[1:0]=00, v[2]=old v[1]), o_pc_en=1.
- Simultaneous: branch and hazard same cycle → FLUSH wins, o_load_use_stall=0, cnt unchanged; i_ext_stall=1 with branch+hazard → all enables 0, v unchanged, branch acts on release cycle.
- Counter saturation: CNT_W=2, force hz 5 cycles → o_stall_count 1,2,3,3,3.
- Async reset mid-run: drop reset between clock edges with pipe full → o_latch_valid=0 and o_stall_count=0 before next edge; re-fill as in first test.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencer: latch valids, enables, load-use bubble, branch flush, freeze
module pipe_ctrl #(
  parameter int STAGES       = 4,
  parameter int BRANCH_STAGE = 1,
  parameter int REG_BITS     = 5,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_fetch_valid,
  input  logic [REG_BITS-1:0] i_id_rs,
  input  logic [REG_BITS-1:0] i_id_rt,
  input  logic                i_id_uses_rs,
  input  logic                i_id_uses_rt,
  input  logic                i_ex_mem_read,
  input  logic [REG_BITS-1:0] i_ex_rt,
  input  logic                i_branch_taken,
  input  logic                i_ext_stall,
  output logic                o_pc_en,
  output logic [STAGES-1:0]   o_latch_en,
  output logic [STAGES-1:0]   o_latch_valid,
  output logic [STAGES-1:0]   o_flush,
  output logic                o_load_use_stall,
  output logic [CNT_W-1:0]    o_stall_count
);

  typedef enum logic [1:0] {
    M_RUN    = 2'd0,
    M_BUBBLE = 2'd1,
    M_FLUSH  = 2'd2,
    M_FREEZE = 2'd3
  } mode_t;

  logic [STAGES-1:0] v, v_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              br, hz;
  mode_t             mode;

  assign br = i_branch_taken & v[BRANCH_STAGE];

  // register 0 is hardwired zero, so a load targeting it can never create a dependency
  assign hz = v[0] & v[1] & i_ex_mem_read & (i_ex_rt != '0) &
              ((i_id_uses_rs & (i_id_rs == i_ex_rt)) |
               (i_id_uses_rt & (i_id_rt == i_ex_rt)));

  always_comb begin
    if (i_ext_stall) mode = M_FREEZE;
    else if (br)     mode = M_FLUSH;
    else if (hz)     mode = M_BUBBLE;
    else             mode = M_RUN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v   <= '0;
      cnt <= '0;
    end else begin
      v   <= v_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    v_nxt   = v;
    cnt_nxt = cnt;
    case (mode)
      M_RUN:    v_nxt = {v[STAGES-2:0], i_fetch_valid};
      M_BUBBLE: begin
        v_nxt = {v[STAGES-2:1], 1'b0, v[0]};
        if (!(&cnt)) cnt_nxt = cnt + 1'b1;
      end
      M_FLUSH: begin
        for (int k = 0; k < STAGES; k++) begin
          if (k <= BRANCH_STAGE) v_nxt[k] = 1'b0;
          else                   v_nxt[k] = v[k-1];
        end
      end
      default: v_nxt = v;
    endcase
  end

  // all strobes are forced low while reset is held, independent of the clock
  always_comb begin
    o_pc_en          = 1'b0;
    o_latch_en       = '0;
    o_flush          = '0;
    o_load_use_stall = 1'b0;
    if (reset) begin
      case (mode)
        M_RUN: begin
          o_pc_en    = 1'b1;
          o_latch_en = '1;
        end
        M_BUBBLE: begin
          o_latch_en       = {{(STAGES-1){1'b1}}, 1'b0};
          o_load_use_stall = 1'b1;
        end
        M_FLUSH: begin
          o_pc_en    = 1'b1;
          o_latch_en = '1;
          for (int k = 0; k < STAGES; k++) o_flush[k] = (k <= BRANCH_STAGE);
        end
        default: ;
      endcase
    end
  end

  assign o_latch_valid = v;
  assign o_stall_count = cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_valid;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        uses_rs, uses_rt, ex_mem_read, branch_taken, ext_stall;
  logic        pc_en, lus;
  logic [3:0]  latch_en, latch_valid, flush;
  logic [15:0] stall_count;
  logic        s_pc_en, s_lus;
  logic [3:0]  s_latch_en, s_latch_valid, s_flush;
  logic [1:0]  s_stall_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic        pc;
    logic [3:0]  le;
    logic [3:0]  fl;
    logic        lus;
    logic [3:0]  v;
    logic [15:0] c;
    int          s;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .i_fetch_valid(fetch_valid),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_branch_taken(branch_taken),
    .i_ext_stall(ext_stall), .o_pc_en(pc_en), .o_latch_en(latch_en),
    .o_latch_valid(latch_valid), .o_flush(flush), .o_load_use_stall(lus),
    .o_stall_count(stall_count)
  );

  pipe_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .i_fetch_valid(fetch_valid),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_branch_taken(branch_taken),
    .i_ext_stall(ext_stall), .o_pc_en(s_pc_en), .o_latch_en(s_latch_en),
    .o_latch_valid(s_latch_valid), .o_flush(s_flush), .o_load_use_stall(s_lus),
    .o_stall_count(s_stall_count)
  );

  task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // monitor: every cycle the stimulus has posted an expectation, pop it and compare
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.nm, "pc_en", {15'd0, pc_en}, {15'd0, e.pc});
        cmp(e.nm, "latch_en", {12'd0, latch_en}, {12'd0, e.le});
        cmp(e.nm, "flush", {12'd0, flush}, {12'd0, e.fl});
        cmp(e.nm, "load_use_stall", {15'd0, lus}, {15'd0, e.lus});
        cmp(e.nm, "latch_valid", {12'd0, latch_valid}, {12'd0, e.v});
        cmp(e.nm, "stall_count", stall_count, e.c);
        if (e.s >= 0) cmp(e.nm, "sat_count", {14'd0, s_stall_count}, e.s[15:0]);
      end
    end
  end

  task automatic post(input string nm, input logic pc, input logic [3:0] le, input logic [3:0] fl,
                      input logic l, input logic [3:0] v, input logic [15:0] c, input int s);
    exp_q.push_back('{nm, pc, le, fl, l, v, c, s});
    @(negedge clk);
  endtask

  task automatic run_(input string nm, input logic [3:0] v, input logic [15:0] c, input int s = -1);
    post(nm, 1'b1, 4'hf, 4'h0, 1'b0, v, c, s);
  endtask
  task automatic bub_(input string nm, input logic [3:0] v, input logic [15:0] c, input int s = -1);
    post(nm, 1'b0, 4'he, 4'h0, 1'b1, v, c, s);
  endtask
  task automatic fls_(input string nm, input logic [3:0] v, input logic [15:0] c, input int s = -1);
    post(nm, 1'b1, 4'hf, 4'h3, 1'b0, v, c, s);
  endtask
  task automatic idle_(input string nm, input logic [3:0] v, input logic [15:0] c, input int s = -1);
    post(nm, 1'b0, 4'h0, 4'h0, 1'b0, v, c, s);
  endtask

  task automatic drv(input logic fv, input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                     input logic [4:0] rt, input logic urs, input logic urt, input logic bt,
                     input logic st);
    fetch_valid = fv; ex_mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
    uses_rs = urs; uses_rt = urt; branch_taken = bt; ext_stall = st;
  endtask

  task automatic quiet();
    drv(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic hazard_rs();
    drv(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    quiet();
    @(negedge clk);
    idle_("rst0", 4'h0, 16'd0, 0);
    idle_("rst1", 4'h0, 16'd0, 0);
    reset = 1'b1;
    run_("fill0", 4'h0, 16'd0);
    run_("fill1", 4'h1, 16'd0);
    run_("fill2", 4'h3, 16'd0);
    run_("fill3", 4'h7, 16'd0);

    hazard_rs();                                         bub_("lu_rs", 4'hf, 16'd0);
    quiet();                                             run_("lu_after", 4'hd, 16'd1);
    drv(1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);             run_("lu_r0", 4'hb, 16'd1);
    drv(1, 1, 5'd7, 5'd3, 5'd7, 1, 1, 0, 0);             bub_("lu_rt", 4'h7, 16'd1);
    quiet();                                             run_("r_a", 4'hd, 16'd2);
    drv(1, 1, 5'd7, 5'd7, 5'd7, 0, 0, 0, 0);             run_("lu_nouse", 4'hb, 16'd2);
    quiet();                                             run_("r_b", 4'h7, 16'd2);

    drv(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);             fls_("br", 4'hf, 16'd2);
    quiet();                                             run_("br_after", 4'hc, 16'd2);
    drv(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);             run_("br_unqual", 4'h9, 16'd2);
    quiet();
    run_("r_c", 4'h3, 16'd2);
    run_("r_d", 4'h7, 16'd2);

    drv(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0);             fls_("br_hz", 4'hf, 16'd2);
    quiet();
    run_("r_e", 4'hc, 16'd2);
    run_("r_f", 4'h9, 16'd2);
    run_("r_g", 4'h3, 16'd2);
    run_("r_h", 4'h7, 16'd2);

    drv(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1);
    idle_("frz0", 4'hf, 16'd2);
    idle_("frz1", 4'hf, 16'd2);
    drv(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0);             fls_("frz_rel", 4'hf, 16'd2);
    quiet();
    run_("r_i", 4'hc, 16'd2);
    run_("r_j", 4'h9, 16'd2);
    run_("r_k", 4'h3, 16'd2);
    run_("r_l", 4'h7, 16'd2);

    // asynchronous reset dropped mid-cycle with a full pipe
    reset = 1'b0;
    idle_("arst0", 4'h0, 16'd0, 0);
    idle_("arst1", 4'h0, 16'd0, 0);
    reset = 1'b1;
    run_("refill0", 4'h0, 16'd0, 0);
    run_("refill1", 4'h1, 16'd0, 0);
    run_("refill2", 4'h3, 16'd0, 0);
    run_("refill3", 4'h7, 16'd0, 0);

    hazard_rs(); bub_("sat1", 4'hf, 16'd0, 0);
    quiet();     run_("sat1r", 4'hd, 16'd1, 1);
    hazard_rs(); bub_("sat2", 4'hb, 16'd1, 1);
    quiet();     run_("sat2r", 4'h5, 16'd2, 2);
    hazard_rs(); bub_("sat3", 4'hb, 16'd2, 2);
    quiet();     run_("sat3r", 4'h5, 16'd3, 3);
    hazard_rs(); bub_("sat4", 4'hb, 16'd3, 3);
    quiet();     run_("sat4r", 4'h5, 16'd4, 3);
    hazard_rs(); bub_("sat5", 4'hb, 16'd4, 3);
    quiet();     run_("sat5r", 4'h5, 16'd5, 3);

    drv(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); run_("nofetch", 4'hb, 16'd5, 3);
    quiet();                                 run_("end", 4'h6, 16'd5, 3);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
